src_phase_sequencer: RTL

- Parametrised successor of the source-phase timing counter in the processor control unit.
- Generates one-hot timing steps T[0..NUM_STEPS-1]. The step at which the counter wraps back to T0 (the "terminal step") is decoded per instruction from opcode and addressing mode.
- Opcode/mode are latched at instruction start, so operand-fetch changes mid-instruction do not disturb the sequence.
- Adds stall, flush, a terminal-step flag, a registered completion pulse and a retired-instruction counter for the control FSM and debug.

---
 rtl/src_phase_sequencer_if.sv | 29 ++
 rtl/src_phase_sequencer.sv | 105 ++++++++++
 2 files changed

// File: rtl/src_phase_sequencer_if.sv
// Control-side bundle for the source-phase sequencer: instruction inputs,
// stall/flush controls and the timing-step outputs.
interface src_phase_sequencer_if #(
  parameter int NUM_STEPS = 8,
  parameter int OPCODE_W  = 6,
  parameter int RETIRE_W  = 16
);
  localparam int STEP_W = $clog2(NUM_STEPS);

  logic [OPCODE_W-1:0]  opcode;
  logic [1:0]           modebits;
  logic                 stall;
  logic                 flush;
  logic [NUM_STEPS-1:0] T;
  logic [STEP_W-1:0]    step;
  logic                 last_step;
  logic                 instr_done;
  logic [RETIRE_W-1:0]  retired;

  modport master (
    output opcode, modebits, stall, flush,
    input  T, step, last_step, instr_done, retired
  );

  modport slave (
    input  opcode, modebits, stall, flush,
    output T, step, last_step, instr_done, retired
  );
endinterface

// File: rtl/src_phase_sequencer.sv
// One-hot timing-step generator whose wrap point is decoded per instruction
// from opcode/addressing mode, with stall, flush, completion pulse and retire count.
module src_phase_sequencer #(
  parameter int NUM_STEPS = 8,
  parameter int OPCODE_W  = 6,
  parameter int RETIRE_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  src_phase_sequencer_if.slave   bus
);
  localparam int STEP_W   = $clog2(NUM_STEPS);
  localparam int MAX_STEP = NUM_STEPS - 1;

  logic [STEP_W-1:0]    r_step;
  logic [OPCODE_W-1:0]  r_opcode;
  logic [1:0]           r_mode;
  logic                 r_instr_done;
  logic [RETIRE_W-1:0]  r_retired;

  logic [OPCODE_W-1:0]  w_dec_opcode;
  logic [1:0]           w_dec_mode;
  logic [STEP_W-1:0]    w_term;
  logic                 w_at_t0;
  logic                 w_illegal;
  logic                 w_last_step;
  logic [NUM_STEPS-1:0] w_t;

  function automatic int raw_term(input logic [OPCODE_W-1:0] op, input logic [1:0] mode);
    int r;
    r = 4;
    case (mode)
      2'b00, 2'b01: r = 2;
      2'b11:        r = 4;
      default: begin
        case (int'(op))
          'h00, 'h01, 'h08, 'h09, 'h0A, 'h0B, 'h20, 'h21, 'h22: r = 3;
          'h10, 'h11, 'h12, 'h15, 'h2A, 'h33:                   r = 2;
          default:                                             r = 4;
        endcase
      end
    endcase
    return r;
  endfunction

  // At T0 the instruction has not been latched yet, so decode from the live bus.
  assign w_at_t0      = (r_step == '0);
  assign w_dec_opcode = w_at_t0 ? bus.opcode   : r_opcode;
  assign w_dec_mode   = w_at_t0 ? bus.modebits : r_mode;

  always_comb begin
    int t;
    t = raw_term(w_dec_opcode, w_dec_mode);
    if (t > MAX_STEP) t = MAX_STEP;
    w_term = STEP_W'(t);
  end

  assign w_illegal   = (int'(r_step) > MAX_STEP);
  assign w_last_step = (r_step == w_term);

  always_comb begin
    // NOTE: default every bit first so the loop can never leave a bit unassigned (no latch).
    w_t = '0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      w_t[i] = (int'(r_step) == i);
    end
  end

  // Priority: flush, then stall, then illegal-step recovery, then wrap or advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step       <= '0;
      r_opcode     <= '0;
      r_mode       <= 2'b00;
      r_instr_done <= 1'b0;
      r_retired    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_instr_done <= 1'b0;
      if (bus.flush) begin
        r_step <= '0;
      end else if (!bus.stall) begin
        if (w_at_t0) begin
          r_opcode <= bus.opcode;
          r_mode   <= bus.modebits;
        end
        if (w_illegal) begin
          r_step <= '0;
        end else if (w_last_step) begin
          r_step       <= '0;
          r_instr_done <= 1'b1;
          r_retired    <= r_retired + RETIRE_W'(1);
        end else begin
          r_step <= r_step + STEP_W'(1);
        end
      end
    end
  end

  assign bus.T          = w_t;
  assign bus.step       = r_step;
  assign bus.last_step  = w_last_step;
  assign bus.instr_done = r_instr_done;
  assign bus.retired    = r_retired;
endmodule
